// File: rtl/mux_rr_arbiter.sv
// mux_rr_arbiter: two-input round-robin arbiter in front of a shared
// two_by_one_mux datapath, with a single registered output stage.
//
// Optional feature macro: MUX_ARB_BURST_EN
//   defined   -> on a tie the last-served source keeps the grant for up to
//                MAX_BURST consecutive beats.
//   undefined -> strict alternation on every tie; no beat counter exists.
//
// Handshake: a beat moves on a port in a cycle where its valid and ready
// are both high at the rising edge. Input readies are combinational from
// the valid inputs, m_ready_in and internal state; producers must not make
// valid depend on ready. The output stage loads whenever it is empty or
// being drained in the same cycle (load = !m_valid_out | m_ready_in).
//
// state_out exposes the arbiter FSM (0 = IDLE, 1 = OWN_X, 2 = OWN_Y).

// One bit of the shared select datapath.
module two_by_one_mux (
  input  logic a,
  input  logic b,
  input  logic sel,
  output logic y
);
  // sel = 0 passes a (X), sel = 1 passes b (Y).
  assign y = sel ? b : a;
endmodule

module mux_rr_arbiter #(
  parameter int WIDTH     = 8,
  parameter int MAX_BURST = 4
) (
  input  logic             clk_in,
  input  logic             reset_in,
  input  logic             x_valid_in,
  input  logic [WIDTH-1:0] x_data_in,
  output logic             x_ready_out,
  input  logic             y_valid_in,
  input  logic [WIDTH-1:0] y_data_in,
  output logic             y_ready_out,
  output logic             m_valid_out,
  output logic [WIDTH-1:0] m_data_out,
  output logic             m_src_out,
  input  logic             m_ready_in,
  output logic             sel_out,
  output logic [1:0]       state_out
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    OWN_X = 2'd1,
    OWN_Y = 2'd2
  } state_t;

  state_t           state_q;
  state_t           state_d;
  logic             last_q;    // last served source: 0 = X, 1 = Y
  logic             sel_q;     // select held between accepts
  logic             load;
  logic             accept;
  logic             win_y;     // winner of this cycle: 0 = X, 1 = Y
  logic             keep_last; // tie resolved in favour of last_q
  logic [WIDTH-1:0] mux_y;

`ifdef MUX_ARB_BURST_EN
  localparam logic [3:0] BURST_LIMIT = 4'(MAX_BURST);
  logic [3:0] cnt_q;

  // A zero count only occurs straight out of reset, when no source has been
  // served yet; the tie then alternates so that X wins the first one.
  assign keep_last = (cnt_q != 4'd0) && (cnt_q < BURST_LIMIT);
`else
  logic [3:0] unused_max_burst;
  assign unused_max_burst = 4'(MAX_BURST);
  assign keep_last        = 1'b0;
`endif

  assign load   = !m_valid_out || m_ready_in;
  assign accept = !reset_in && load && (x_valid_in || y_valid_in);

  // Pick the winner from the valid inputs and the round-robin pointer.
  always_comb begin
    win_y = 1'b0;
    case ({x_valid_in, y_valid_in})
      2'b10:   win_y = 1'b0;
      2'b01:   win_y = 1'b1;
      2'b11:   win_y = keep_last ? last_q : !last_q;
      default: win_y = 1'b0;
    endcase
  end

  assign x_ready_out = accept && !win_y;
  assign y_ready_out = accept &&  win_y;

  // The select only moves when a word is actually taken, so the shared mux
  // never switches under a held output.
  assign sel_out = reset_in ? 1'b0 : (accept ? win_y : sel_q);

  // Shared datapath: one mux per data bit.
  for (genvar i = 0; i < WIDTH; i++) begin : g_mux
    two_by_one_mux u_mux (
      .a   (x_data_in[i]),
      .b   (y_data_in[i]),
      .sel (sel_out),
      .y   (mux_y[i])
    );
  end

  // FSM next state: only moves on cycles where the output stage can load.
  always_comb begin
    state_d = state_q;
    if (load) begin
      if (accept) state_d = win_y ? OWN_Y : OWN_X;
      else        state_d = IDLE;
    end
  end

  // FSM state register.
  always_ff @(posedge clk_in) begin
    if (reset_in) state_q <= IDLE;
    else          state_q <= state_d;
  end

  assign state_out = state_q;

  // Output stage, round-robin pointer and held select.
  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      m_valid_out <= 1'b0;
      m_data_out  <= '0;
      m_src_out   <= 1'b0;
      last_q      <= 1'b1;
      sel_q       <= 1'b0;
    end else begin
      sel_q <= sel_out;
      if (accept) begin
        m_valid_out <= 1'b1;
        m_data_out  <= mux_y;
        m_src_out   <= win_y;
        last_q      <= win_y;
      end else if (load) begin
        m_valid_out <= 1'b0;
      end
    end
  end

`ifdef MUX_ARB_BURST_EN
  // Consecutive beats granted to last_q, saturating at 15.
  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      cnt_q <= 4'd0;
    end else if (accept) begin
      if (win_y == last_q) cnt_q <= (cnt_q == 4'd15) ? 4'd15 : cnt_q + 4'd1;
      else                 cnt_q <= 4'd1;
    end
  end
`endif

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// tb_mux_rr_arbiter: directed checks plus a randomized run against a
// behavioural model of the arbiter, with per-source scoreboards.
module tb_mux_rr_arbiter;

`ifdef MUX_ARB_BURST_EN
  localparam int  MB    = 3;
  localparam bit  BURST = 1'b1;
`else
  localparam int  MB    = 4;
  localparam bit  BURST = 1'b0;
`endif
  localparam int W = 8;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         reset_in;
  logic         x_valid, y_valid, m_ready;
  logic [W-1:0] x_data, y_data;
  logic         x_ready, y_ready, m_valid, m_src, sel;
  logic [W-1:0] m_data;
  logic [1:0]   state;

  mux_rr_arbiter #(.WIDTH(W), .MAX_BURST(MB)) dut (
    .clk_in      (clk),
    .reset_in    (reset_in),
    .x_valid_in  (x_valid),
    .x_data_in   (x_data),
    .x_ready_out (x_ready),
    .y_valid_in  (y_valid),
    .y_data_in   (y_data),
    .y_ready_out (y_ready),
    .m_valid_out (m_valid),
    .m_data_out  (m_data),
    .m_src_out   (m_src),
    .m_ready_in  (m_ready),
    .sel_out     (sel),
    .state_out   (state)
  );

  // ---------------- bookkeeping ----------------
  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=0x%0h required=0x%0h at %0t", name, act, req, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Holder of the output word, who owns the link, and how long the current
  // owner has been streaking.
  int          mv, mdat, msrc, mst, msel;
  int          owner;   // last served source, 0 = X, 1 = Y
  int          streak;  // beats in a row to owner (0 = nobody served yet)
  int          e_load, e_acc, e_win, e_sel;
  logic [W-1:0] exp_q_x[$];
  logic [W-1:0] exp_q_y[$];
  int          wait_x, wait_y;
  bit          fair_on;

  task automatic model_reset();
    mv = 0; mdat = 0; msrc = 0; mst = 0; msel = 0;
    owner = 1; streak = 0;
    exp_q_x.delete(); exp_q_y.delete();
    wait_x = 0; wait_y = 0;
  endtask

  task automatic model_comb();
    e_load = (mv == 0 || m_ready) ? 1 : 0;
    if (x_valid && !y_valid)      e_win = 0;
    else if (y_valid && !x_valid) e_win = 1;
    else if (x_valid && y_valid) begin
      if (BURST && streak >= 1 && streak < MB) e_win = owner;
      else                                     e_win = 1 - owner;
    end else e_win = 0;
    e_acc = (!reset_in && e_load == 1 && (x_valid || y_valid)) ? 1 : 0;
    e_sel = reset_in ? 0 : (e_acc == 1 ? e_win : msel);
  endtask

  task automatic model_edge();
    if (reset_in) begin
      model_reset();
    end else if (e_acc == 1) begin
      mdat  = (e_win == 1) ? int'(y_data) : int'(x_data);
      msrc  = e_win;
      mv    = 1;
      streak = (e_win == owner) ? ((streak >= 15) ? 15 : streak + 1) : 1;
      owner = e_win;
      mst   = e_win + 1;
      msel  = e_win;
    end else if (e_load == 1) begin
      mv  = 0;
      mst = 0;
    end
  endtask

  // ---------------- per-cycle compare + scoreboard ----------------
  task automatic compare_cycle();
    logic [W-1:0] exp_w;
    chk("x_ready", x_ready, (e_acc == 1 && e_win == 0) ? 1 : 0);
    chk("y_ready", y_ready, (e_acc == 1 && e_win == 1) ? 1 : 0);
    chk("one_ready", x_ready & y_ready, 0);
    chk("sel", sel, e_sel);
    chk("m_valid", m_valid, mv);
    chk("state", state, mst);
    if (mv == 1) begin
      chk("m_src", m_src, msrc);
      chk("m_data", m_data, mdat);
    end
    // Drain: the departing word must be the oldest one owed for its source.
    if (!reset_in && mv == 1 && m_ready) begin
      if (msrc == 0) begin
        if (exp_q_x.size() == 0) chk("sb_x_empty", 1, 0);
        else begin exp_w = exp_q_x.pop_front(); chk("sb_x", m_data, exp_w); end
      end else begin
        if (exp_q_y.size() == 0) chk("sb_y_empty", 1, 0);
        else begin exp_w = exp_q_y.pop_front(); chk("sb_y", m_data, exp_w); end
      end
    end
    if (e_acc == 1) begin
      if (e_win == 0) exp_q_x.push_back(x_data);
      else            exp_q_y.push_back(y_data);
    end
    // Fairness: grants to the other side while a source sits valid.
    if (fair_on && e_acc == 1) begin
      if (x_valid && e_win == 1) wait_x++;
      if (y_valid && e_win == 0) wait_y++;
      chk("fair_x", (wait_x <= (BURST ? MB : 1)) ? 1 : 0, 1);
      chk("fair_y", (wait_y <= (BURST ? MB : 1)) ? 1 : 0, 1);
    end
    if (!x_valid || (e_acc == 1 && e_win == 0)) wait_x = 0;
    if (!y_valid || (e_acc == 1 && e_win == 1)) wait_y = 0;
  endtask

  // ---------------- driver tasks ----------------
  task automatic set_in(input logic xv, input logic [W-1:0] xd,
                        input logic yv, input logic [W-1:0] yd, input logic mr);
    x_valid = xv; x_data = xd; y_valid = yv; y_data = yd; m_ready = mr;
  endtask

  // One clock: compare with the inputs settled, then advance the model.
  task automatic step();
    #1;
    model_comb();
    compare_cycle();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic pulse_reset();
    reset_in = 1'b1;
    step();
    reset_in = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  logic [6:0] src_pat;
  int         n_beats;
  logic [W-1:0] x_seq, y_seq;

  initial begin
    fair_on = 1'b0;
    model_reset();
    reset_in = 1'b1;
    set_in(1'b0, '0, 1'b0, '0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    step();                      // readies/sel must be 0 during reset
    reset_in = 1'b0;

    // Idle after reset: everything stays at reset values.
    for (int i = 0; i < 5; i++) begin
      step();
      chk("idle_valid", m_valid, 0);
      chk("idle_data", m_data, 0);
      chk("idle_state", state, 0);
      chk("idle_sel", sel, 0);
    end

    // Reset discards a held word.
    set_in(1'b1, 8'h77, 1'b0, '0, 1'b0);
    step();
    chk("hold_77", m_data, 8'h77);
    chk("hold_77_v", m_valid, 1);
    pulse_reset();
    chk("rst_drop", m_valid, 0);

    // X only, streaming.
    for (int i = 0; i < 4; i++) begin
      set_in(1'b1, 8'h11 + W'(i), 1'b0, '0, 1'b1);
      step();
      chk("xonly_data", m_data, 8'h11 + i);
      chk("xonly_src", m_src, 0);
      chk("xonly_sel", sel, 0);
    end
    set_in(1'b0, '0, 1'b0, '0, 1'b1);
    step();

    // Both valid continuously from a fresh reset.
    pulse_reset();
    if (BURST) begin src_pat = 7'b0111000; n_beats = 7; end
    else       begin src_pat = 7'b0001010; n_beats = 4; end
    for (int i = 0; i < n_beats; i++) begin
      set_in(1'b1, 8'hAA, 1'b1, 8'h55, 1'b1);
      step();
      chk("tie_src", m_src, src_pat[i]);
      chk("tie_data", m_data, src_pat[i] ? 8'h55 : 8'hAA);
    end
    set_in(1'b0, '0, 1'b0, '0, 1'b1);
    step();

    // Backpressure on a held 0x3C, then release with a new word waiting.
    set_in(1'b1, 8'h3C, 1'b0, '0, 1'b1);
    step();
    set_in(1'b1, 8'h3D, 1'b1, 8'h66, 1'b0);
    for (int i = 0; i < 4; i++) begin
      step();
      chk("bp_data", m_data, 8'h3C);
      chk("bp_valid", m_valid, 1);
      chk("bp_xready", x_ready, 0);
      chk("bp_yready", y_ready, 0);
    end
    set_in(1'b1, 8'h3D, 1'b0, 8'h66, 1'b1);
    step();
    chk("release_data", m_data, 8'h3D);
    chk("release_valid", m_valid, 1);
    set_in(1'b0, '0, 1'b0, '0, 1'b1);
    step();
    chk("drained", m_valid, 0);

    // Randomized traffic.
    pulse_reset();
    fair_on = 1'b1;
    x_seq = '0;
    y_seq = 8'h80;
    for (int cyc = 0; cyc < 10000; cyc++) begin
      reset_in = (cyc % 3333 == 3332);
      set_in($urandom_range(0, 3) != 0, x_seq, $urandom_range(0, 3) != 0, y_seq,
             $urandom_range(0, 9) < 7);
      step();
      if (e_acc == 1 && e_win == 0) x_seq = x_seq + 1'b1;
      if (e_acc == 1 && e_win == 1) y_seq = y_seq + 1'b1;
    end
    reset_in = 1'b0;
    set_in(1'b0, '0, 1'b0, '0, 1'b1);
    step();
    step();
    chk("end_qx", exp_q_x.size(), 0);
    chk("end_qy", exp_q_y.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
